mem_port_arbiter: RTL and testbench

- Shares one external memory port (address/data, MREQ/WRITE/SIZE, active-low ACK) between the core's instruction-fetch requester and its data-access requester.
- Sits between the pipeline datapath and the top-level memory pins.
- Grants one transaction at a time, with fixed data priority bounded by a fetch anti-starvation limit.
- Returns one-cycle completion strobes and a bus-timeout error.

---
 rtl/mem_port_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares a single external memory port between the core's instruction-fetch
// requester and its data-access requester. One transaction is in flight at a
// time. Data wins arbitration by default. A streak counter stops data from
// winning more than MAX_D_STREAK times in a row while a fetch is waiting.
// A watchdog aborts any transaction that is not acknowledged within TIMEOUT
// busy cycles.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   i_req / i_addr    fetch request level and address (held until i_ack)
//   i_rdata / i_ack   fetched word and one-cycle completion strobe
//   d_req / d_we      data request level; 1 = store, 0 = load
//   d_size            00 word, 01 half, 10 byte
//   d_addr / d_wdata  data address and right-aligned store data
//   d_rdata / d_ack   load data and one-cycle completion strobe
//   bus_err           one-cycle strobe; the granted transaction timed out
//   m_req ... m_wdata registered external MREQ/WRITE/SIZE/address/data
//   m_rdata           external read data
//   m_ack_n           external active-low acknowledge
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int MAX_D_STREAK = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic [DW-1:0] i_rdata,
   output logic          i_ack,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [1:0]    d_size,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ack,
   output logic          bus_err,
   output logic          m_req,
   output logic          m_write,
   output logic [1:0]    m_size,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata,
   input  logic          m_ack_n
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_IBUS = 2'd1;
   localparam logic [1:0] ST_DBUS = 2'd2;

   localparam logic [3:0]  LP_MAX_STREAK = 4'(MAX_D_STREAK);
   // Last count value before the watchdog fires.
   localparam logic [15:0] LP_TMO_LAST   = 16'(TIMEOUT - 1);

   logic [1:0]    r_state;
   logic [3:0]    r_streak;
   logic [15:0]   r_tmo;
   logic          r_m_req;
   logic          r_m_write;
   logic [1:0]    r_m_size;
   logic [AW-1:0] r_m_addr;
   logic [DW-1:0] r_m_wdata;
   logic [DW-1:0] r_i_rdata;
   logic [DW-1:0] r_d_rdata;
   logic          r_i_ack;
   logic          r_d_ack;
   logic          r_bus_err;

   logic w_busy;
   logic w_ack_edge;
   logic w_tmo_edge;
   logic w_arb_en;
   logic w_i_cand;
   logic w_d_cand;
   logic w_streak_full;
   logic w_grant_d;
   logic w_grant_i;

   // Saturating increment of the data-grant streak.
   function automatic logic [3:0] f_streak_inc(input logic [3:0] s);
      if (s >= LP_MAX_STREAK) begin
         return LP_MAX_STREAK;
      end
      return s + 4'd1;
   endfunction

   // m_req is high exactly while a transaction owns the bus, so ack is only
   // honoured in the busy states.
   assign w_busy     = (r_state != ST_IDLE);
   assign w_ack_edge = w_busy & ~m_ack_n;
   // Ack has priority over the watchdog on the same edge.
   assign w_tmo_edge = w_busy & m_ack_n & (r_tmo == LP_TMO_LAST);

   // Arbitrate when idle, or on the ack edge for back-to-back operation.
   assign w_arb_en = (r_state == ST_IDLE) | w_ack_edge;

   // The completing requester still holds its req on the ack edge; mask it.
   assign w_i_cand = i_req & ~((r_state == ST_IBUS) & w_ack_edge);
   assign w_d_cand = d_req & ~((r_state == ST_DBUS) & w_ack_edge);

   assign w_streak_full = (r_streak == LP_MAX_STREAK);
   assign w_grant_d     = w_arb_en & w_d_cand & ~(w_streak_full & w_i_cand);
   assign w_grant_i     = w_arb_en & w_i_cand & ~w_grant_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_streak  <= '0;
         r_tmo     <= '0;
         r_m_req   <= 1'b0;
         r_m_write <= 1'b0;
         r_m_size  <= '0;
         r_m_addr  <= '0;
         r_m_wdata <= '0;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
         r_i_ack   <= 1'b0;
         r_d_ack   <= 1'b0;
         r_bus_err <= 1'b0;
      end else begin
         r_i_ack   <= 1'b0;
         r_d_ack   <= 1'b0;
         r_bus_err <= 1'b0;

         // Completion of the current owner: normal ack or watchdog abort.
         if (w_ack_edge) begin
            if (r_state == ST_IBUS) begin
               r_i_ack   <= 1'b1;
               r_i_rdata <= m_rdata;
            end else begin
               r_d_ack <= 1'b1;
               if (!r_m_write) begin
                  r_d_rdata <= m_rdata;
               end
            end
         end else if (w_tmo_edge) begin
            r_bus_err <= 1'b1;
            if (r_state == ST_IBUS) begin
               r_i_ack   <= 1'b1;
               r_i_rdata <= '0;
            end else begin
               r_d_ack <= 1'b1;
               if (!r_m_write) begin
                  r_d_rdata <= '0;
               end
            end
         end else if (w_busy) begin
            r_tmo <= r_tmo + 16'd1;
         end

         // New grant, or release of the bus when nobody else is waiting.
         if (w_grant_d) begin
            r_state   <= ST_DBUS;
            r_m_req   <= 1'b1;
            r_m_write <= d_we;
            r_m_size  <= d_size;
            r_m_addr  <= d_addr;
            r_m_wdata <= d_wdata;
            r_tmo     <= '0;
            // Only a fetch that is genuinely left waiting extends the streak.
            r_streak  <= w_i_cand ? f_streak_inc(r_streak) : 4'd0;
         end else if (w_grant_i) begin
            r_state   <= ST_IBUS;
            r_m_req   <= 1'b1;
            r_m_write <= 1'b0;
            r_m_size  <= 2'b00;
            r_m_addr  <= i_addr;
            r_tmo     <= '0;
            r_streak  <= '0;
         end else if (w_ack_edge || w_tmo_edge) begin
            r_state <= ST_IDLE;
            r_m_req <= 1'b0;
            r_tmo   <= '0;
         end
      end
   end

   assign i_rdata = r_i_rdata;
   assign i_ack   = r_i_ack;
   assign d_rdata = r_d_rdata;
   assign d_ack   = r_d_ack;
   assign bus_err = r_bus_err;
   assign m_req   = r_m_req;
   assign m_write = r_m_write;
   assign m_size  = r_m_size;
   assign m_addr  = r_m_addr;
   assign m_wdata = r_m_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// The driver acts as both requesters and as the external memory. For every
// edge it drives, a transaction-level reference model decides who owns the
// bus, and it queues the expected grants, completions and m_req levels. An
// independent monitor pops those queues when the DUT shows a grant or an ack.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int MAXS = 2;
   localparam int TMO  = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_rdata;
   logic          i_ack;
   logic          d_req;
   logic          d_we;
   logic [1:0]    d_size;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_ack;
   logic          bus_err;
   logic          m_req;
   logic          m_write;
   logic [1:0]    m_size;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;
   logic          m_ack_n;

   mem_port_arbiter #(
      .AW(AW), .DW(DW), .MAX_D_STREAK(MAXS), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack), .bus_err(bus_err),
      .m_req(m_req), .m_write(m_write), .m_size(m_size), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack_n(m_ack_n)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            cyc;
      logic          is_d;
      logic [DW-1:0] rdata;
      logic          err;
   } done_t;

   typedef struct {
      int            cyc;
      logic          is_d;
      logic [AW-1:0] addr;
      logic          we;
      logic [1:0]    sz;
      logic [DW-1:0] wd;
   } grant_t;

   typedef struct {
      int   cyc;
      logic mreq;
   } bus_t;

   done_t  dq[$];
   grant_t gq[$];
   bus_t   bq[$];
   int     rq[$];

   // Reference model state: bus owner (0 none, 1 fetch, 2 data).
   int            own      = 0;
   int            streak   = 0;
   int            waited   = 0;
   logic          cur_we   = 1'b0;
   logic          hang     = 1'b0;
   logic [DW-1:0] last_drd = '0;
   logic          f_done   = 1'b0;
   logic          d_done   = 1'b0;
   logic          tb_done  = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void chk(input string nm, input logic [63:0] act,
                               input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic void model_complete(input logic [DW-1:0] rd, input logic err);
      done_t e;
      e.cyc  = cyc + 1;
      e.is_d = (own == 2);
      e.err  = err;
      if (own == 2) begin
         if (!cur_we) last_drd = err ? '0 : rd;
         e.rdata = last_drd;
         d_done  = 1'b1;
      end else begin
         e.rdata = err ? '0 : rd;
         f_done  = 1'b1;
      end
      dq.push_back(e);
   endfunction

   function automatic void model_grant(input logic is_d);
      grant_t g;
      g.cyc  = cyc + 1;
      g.is_d = is_d;
      if (is_d) begin
         g.addr = d_addr; g.we = d_we; g.sz = d_size; g.wd = d_wdata;
         own = 2; cur_we = d_we;
      end else begin
         g.addr = i_addr; g.we = 1'b0; g.sz = 2'b00; g.wd = '0;
         own = 1; cur_we = 1'b0;
      end
      waited = 0;
      hang   = ($urandom_range(0, 9) == 0);
      gq.push_back(g);
   endfunction

   // Drive one edge: apply memory/reset inputs, predict the edge, advance.
   task automatic step(input logic ack_n, input logic [DW-1:0] rd, input logic do_rst);
      int   done_by;
      logic fi;
      logic fd;
      logic arb;
      bus_t b;
      m_ack_n = ack_n;
      m_rdata = rd;
      rst     = do_rst;
      if (do_rst) begin
         own = 0; streak = 0; waited = 0; last_drd = '0;
         f_done = 1'b0; d_done = 1'b0;
         rq.push_back(cyc + 1);
      end else begin
         done_by = 0;
         arb     = (own == 0);
         if (own != 0) begin
            if (!ack_n) begin
               model_complete(rd, 1'b0);
               done_by = own; own = 0; arb = 1'b1;
            end else if (waited + 1 >= TMO) begin
               model_complete('0, 1'b1);
               own = 0;
            end else begin
               waited++;
            end
         end
         if (arb) begin
            fi = i_req && (done_by != 1);
            fd = d_req && (done_by != 2);
            if (fd && !(streak == MAXS && fi)) begin
               model_grant(1'b1);
               streak = fi ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
            end else if (fi) begin
               model_grant(1'b0);
               streak = 0;
            end
         end
      end
      b.cyc  = cyc + 1;
      b.mreq = (own != 0);
      bq.push_back(b);
      @(posedge clk);
      #1;
      if (do_rst) begin
         i_req = 1'b0;
         d_req = 1'b0;
      end
      if (f_done) begin i_req = 1'b0; f_done = 1'b0; end
      if (d_done) begin d_req = 1'b0; d_done = 1'b0; end
      rst = 1'b0;
   endtask

   // mode 0: random traffic; mode 1: both always requesting, data never acked.
   task automatic run(input int n, input int mode);
      logic an;
      for (int k = 0; k < n; k++) begin
         if (!i_req && (mode == 1 || $urandom_range(0, 2) == 0)) begin
            i_req  = 1'b1;
            i_addr = $urandom;
         end
         if (!d_req && (mode == 1 || $urandom_range(0, 2) == 0)) begin
            d_req   = 1'b1;
            d_we    = 1'($urandom);
            d_size  = 2'($urandom_range(0, 2));
            d_addr  = $urandom;
            d_wdata = $urandom;
         end
         if (own == 2 && mode == 1)      an = 1'b1;
         else if (own == 1 && mode == 1) an = 1'b0;
         else if (own != 0 && hang)      an = 1'b1;
         else                            an = 1'($urandom_range(0, 1));
         step(an, $urandom, (mode == 0) && ($urandom_range(0, 199) == 0));
      end
   endtask

   initial begin : driver
      i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_size = 2'b00;
      d_addr = '0; d_wdata = '0; m_rdata = '0; m_ack_n = 1'b1; rst = 1'b1;
      step(1'b1, '0, 1'b1);
      step(1'b1, '0, 1'b1);
      step(1'b0, '0, 1'b0);          // ack while idle must be ignored

      // Single fetch, memory acks on the first m_req cycle.
      i_req = 1'b1; i_addr = 32'h0000_0040;
      step(1'b1, '0, 1'b0);
      step(1'b0, 32'h0010_0093, 1'b0);
      step(1'b1, '0, 1'b0);

      // Both requesting: byte store first, then fetch back-to-back.
      i_req = 1'b1; i_addr = 32'h0000_0080;
      d_req = 1'b1; d_we = 1'b1; d_size = 2'b10;
      d_addr = 32'hF000_0000; d_wdata = 32'h0000_0041;
      step(1'b1, '0, 1'b0);
      step(1'b0, 32'h1111_2222, 1'b0);
      step(1'b0, 32'h0000_0013, 1'b0);
      step(1'b1, '0, 1'b0);

      // Load that is never acknowledged, then a normal load.
      d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_addr = 32'h0800_0010;
      step(1'b1, 32'hDEAD_BEEF, 1'b0);
      repeat (TMO) step(1'b1, 32'hDEAD_BEEF, 1'b0);
      step(1'b1, '0, 1'b0);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0800_0014;
      step(1'b1, '0, 1'b0);
      step(1'b0, 32'h5A5A_0001, 1'b0);
      step(1'b1, '0, 1'b0);

      // Ack arrives on the very edge the watchdog would fire.
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0800_0020;
      step(1'b1, '0, 1'b0);
      repeat (TMO - 1) step(1'b1, '0, 1'b0);
      step(1'b0, 32'hCAFE_F00D, 1'b0);
      step(1'b1, '0, 1'b0);

      // Reset while a store owns the bus, then a fetch.
      d_req = 1'b1; d_we = 1'b1; d_size = 2'b01;
      d_addr = 32'h0000_2000; d_wdata = 32'h0000_BEEF;
      step(1'b1, '0, 1'b0);
      step(1'b1, '0, 1'b0);
      step(1'b0, 32'h7777_7777, 1'b1);
      step(1'b1, '0, 1'b0);
      i_req = 1'b1; i_addr = 32'h0000_0100;
      step(1'b1, '0, 1'b0);
      step(1'b1, '0, 1'b0);
      step(1'b0, 32'h0000_0297, 1'b0);
      step(1'b1, '0, 1'b0);

      // Streak limit: fetch waits while data keeps timing out.
      run(80, 1);
      // Random traffic with random waits, hangs and occasional reset.
      run(1500, 0);

      // Drain: ack everything still outstanding.
      for (int k = 0; k < 60 && (i_req || d_req); k++) step(1'b0, $urandom, 1'b0);
      repeat (3) step(1'b1, '0, 1'b0);
      tb_done = 1'b1;
   end

   initial begin : monitor
      logic   prev_mreq;
      done_t  e;
      grant_t g;
      bus_t   b;
      prev_mreq = 1'b0;
      forever begin
         @(negedge clk);
         if (rq.size() > 0 && rq[0] == cyc) begin
            void'(rq.pop_front());
            chk("reset_ctrl", 64'({m_req, m_write, m_size, i_ack, d_ack, bus_err}), 64'd0);
            chk("reset_m_addr_wdata", 64'({m_addr, m_wdata}), 64'd0);
            chk("reset_rdata", 64'({i_rdata, d_rdata}), 64'd0);
         end
         if (bq.size() > 0 && bq[0].cyc == cyc) begin
            b = bq.pop_front();
            chk("m_req", 64'(m_req), 64'(b.mreq));
            chk("ack_exclusive", 64'(i_ack & d_ack), 64'd0);
            chk("bus_err_without_ack", 64'(bus_err & ~(i_ack | d_ack)), 64'd0);
         end
         if (i_ack === 1'b1 || d_ack === 1'b1) begin
            chk("ack_expected", 64'(dq.size() != 0), 64'd1);
            if (dq.size() != 0) begin
               e = dq.pop_front();
               chk("ack_cycle", 64'(cyc), 64'(e.cyc));
               chk("ack_port_is_data", 64'(d_ack), 64'(e.is_d));
               chk("bus_err", 64'(bus_err), 64'(e.err));
               if (e.is_d) chk("d_rdata", 64'(d_rdata), 64'(e.rdata));
               else        chk("i_rdata", 64'(i_rdata), 64'(e.rdata));
            end
         end
         if (m_req === 1'b1 && (!prev_mreq || i_ack === 1'b1 || d_ack === 1'b1)) begin
            chk("grant_expected", 64'(gq.size() != 0), 64'd1);
            if (gq.size() != 0) begin
               g = gq.pop_front();
               chk("grant_cycle", 64'(cyc), 64'(g.cyc));
               chk("m_addr", 64'(m_addr), 64'(g.addr));
               chk("m_write", 64'(m_write), 64'(g.we));
               chk("m_size", 64'(m_size), 64'(g.sz));
               if (g.is_d) chk("m_wdata", 64'(m_wdata), 64'(g.wd));
            end
         end
         prev_mreq = (m_req === 1'b1);
         if (tb_done || cyc > 20000) begin
            chk("run_completed", 64'(tb_done), 64'd1);
            chk("acks_outstanding", 64'(dq.size()), 64'd0);
            chk("grants_outstanding", 64'(gq.size()), 64'd0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
         end
      end
   end

endmodule
